// File: rtl/compar_pkg.sv
// Shared types for the compar_* family: FSM states, the one-hot result and the counter sizing.
package compar_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_res_t;

   function automatic int cnt_w(input int width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/compar_serial_if.sv
// Operand beats in, one-hot result out with valid/ready; master is the driver side.
interface compar_serial_if;
   logic start;
   logic bit_valid;
   logic a_bit;
   logic b_bit;
   logic res_ready;
   logic busy;
   logic res_valid;
   logic A_gt_B;
   logic A_eq_B;
   logic A_lt_B;
   logic protocol_err;

   modport master (
      output start, bit_valid, a_bit, b_bit, res_ready,
      input  busy, res_valid, A_gt_B, A_eq_B, A_lt_B, protocol_err
   );

   modport slave (
      input  start, bit_valid, a_bit, b_bit, res_ready,
      output busy, res_valid, A_gt_B, A_eq_B, A_lt_B, protocol_err
   );
endinterface

// File: rtl/compar_serial_cell.sv
// MSB-first decision latch: the first differing bit pair fixes gt/lt, later bits are ignored.
module compar_serial_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic beat,
   input  logic a_bit,
   input  logic b_bit,
   output logic decided,
   output logic gt,
   output logic lt
);

   logic dec_q, gt_q, lt_q;

   // Outputs already include this cycle's beat so the final bit can be folded into the result.
   always_comb begin
      decided = dec_q;
      gt      = gt_q;
      lt      = lt_q;
      if (clr) begin
         decided = 1'b0;
         gt      = 1'b0;
         lt      = 1'b0;
      end else if (beat && !dec_q && (a_bit != b_bit)) begin
         decided = 1'b1;
         gt      = a_bit;
         lt      = b_bit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q <= 1'b0;
         gt_q  <= 1'b0;
         lt_q  <= 1'b0;
      end else begin
         dec_q <= decided;
         gt_q  <= gt;
         lt_q  <= lt;
      end
   end

endmodule

// File: rtl/compar_serial.sv
// Bit-serial unsigned magnitude comparator with registered one-hot result and valid/ready handshake.
module compar_serial
   import compar_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   compar_serial_if.slave bus
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   cmp_res_t         res, res_nxt;
   logic             perr_nxt, perr;
   logic             busy_q, rv_q;
   logic             clr, beat;
   logic             dec_nxt, gt_nxt, lt_nxt;

   compar_serial_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .beat    (beat),
      .a_bit   (bus.a_bit),
      .b_bit   (bus.b_bit),
      .decided (dec_nxt),
      .gt      (gt_nxt),
      .lt      (lt_nxt)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      res_nxt   = res;
      perr_nxt  = 1'b0;
      clr       = 1'b0;
      beat      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = SHIFT;
               cnt_nxt   = '0;
               clr       = 1'b1;
            end
         end
         SHIFT: begin
            // A restart drops any bit presented on the same cycle.
            if (bus.start) begin
               cnt_nxt  = '0;
               clr      = 1'b1;
               perr_nxt = 1'b1;
            end else if (bus.bit_valid) begin
               beat = 1'b1;
               if (cnt == LAST) begin
                  state_nxt = HOLD;
                  cnt_nxt   = '0;
                  res_nxt   = '{gt: gt_nxt, eq: ~dec_nxt, lt: lt_nxt};
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (bus.res_ready) begin
               res_nxt = '0;
               if (bus.start) begin
                  state_nxt = SHIFT;
                  cnt_nxt   = '0;
                  clr       = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (bus.start) begin
               perr_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            res_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         res    <= '0;
         perr   <= 1'b0;
         busy_q <= 1'b0;
         rv_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         res    <= res_nxt;
         perr   <= perr_nxt;
         busy_q <= (state_nxt == SHIFT);
         rv_q   <= (state_nxt == HOLD);
      end
   end

   assign bus.busy         = busy_q;
   assign bus.res_valid    = rv_q;
   assign bus.A_gt_B       = res.gt;
   assign bus.A_eq_B       = res.eq;
   assign bus.A_lt_B       = res.lt;
   assign bus.protocol_err = perr;

endmodule

// File: tb/tb_compar_serial.sv
// Scoreboarded bench for compar_serial at WIDTH=8 (idx0), 2 (idx1) and 1 (idx2).
module tb_compar_serial;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] st = '0, bv = '0, ab = '0, bb = '0, rr = '0;
   wire  [2:0] bsy, rv, fgt, feq, flt, pe;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 8 : (g == 1) ? 2 : 1;
      compar_serial_if bus ();
      assign bus.start     = st[g];
      assign bus.bit_valid = bv[g];
      assign bus.a_bit     = ab[g];
      assign bus.b_bit     = bb[g];
      assign bus.res_ready = rr[g];
      assign bsy[g] = bus.busy;
      assign rv[g]  = bus.res_valid;
      assign fgt[g] = bus.A_gt_B;
      assign feq[g] = bus.A_eq_B;
      assign flt[g] = bus.A_lt_B;
      assign pe[g]  = bus.protocol_err;
      compar_serial #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   end

   int checks = 0, failures = 0;
   int cyc = 0;
   int t0[3];
   int perr_cnt[3] = '{0, 0, 0};
   logic [2:0] sb_q[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) for (int i = 0; i < 3; i++) if (pe[i]) perr_cnt[i] <= perr_cnt[i] + 1;

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      int         gaps;
      logic [2:0] exp;   // {gt, eq, lt}
   } vec_t;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int idx, input logic rdy);
      st[idx] = 1'b1;
      rr[idx] = rdy;
      step();
      st[idx] = 1'b0;
      rr[idx] = 1'b0;
      t0[idx] = cyc;
   endtask

   // Expected result is queued as soon as the operand stream is driven.
   task automatic send_bits(input int idx, input int w, input logic [7:0] a, input logic [7:0] b,
                            input int gaps, input logic [2:0] exp);
      sb_q.push_back(exp);
      for (int i = w - 1; i >= 0; i--) begin
         if (gaps > 0 && (w - 1 - i) == w / 2) begin
            for (int k = 0; k < gaps; k++) begin
               bv[idx] = 1'b0;
               ab[idx] = 1'($urandom);
               bb[idx] = 1'($urandom);
               step();
            end
         end
         bv[idx] = 1'b1;
         ab[idx] = a[i];
         bb[idx] = b[i];
         step();
      end
      bv[idx] = 1'b0;
   endtask

   task automatic check_result(input int idx, input string name, input int exp_cycle);
      int n;
      logic [2:0] exp;
      n = 0;
      while (!rv[idx] && n < 40) begin
         step();
         n++;
      end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 3'b000;
      check({name, "_valid"}, int'(rv[idx]), 1);
      check({name, "_flags"}, int'({fgt[idx], feq[idx], flt[idx]}), int'(exp));
      check({name, "_cycle"}, cyc - t0[idx] + 1, exp_cycle);
   endtask

   task automatic consume(input int idx, input string name);
      rr[idx] = 1'b1;
      step();
      rr[idx] = 1'b0;
      check({name, "_drop"}, int'({rv[idx], fgt[idx], feq[idx], flt[idx]}), 0);
   endtask

   initial begin
      vec_t vecs[7];
      logic [2:0] held;
      int p;

      vecs[0] = '{"eq_a5",    8'hA5, 8'hA5, 0, 3'b010};
      vecs[1] = '{"gt_msb",   8'h80, 8'h7F, 0, 3'b100};
      vecs[2] = '{"gt_rnd",   8'h80, {1'b0, 7'($urandom)}, 0, 3'b100};
      vecs[3] = '{"lt_gaps",  8'h3C, 8'h3D, 3, 3'b001};
      vecs[4] = '{"lt_zero",  8'h00, 8'hFF, 0, 3'b001};
      vecs[5] = '{"gt_lsb",   8'hFF, 8'hFE, 1, 3'b100};
      vecs[6] = '{"eq_zero",  8'h00, 8'h00, 0, 3'b010};

      #12;
      check("rst_outs", int'({bsy, rv, fgt, feq, flt, pe}), 0);
      rst_n = 1'b1;
      step();

      foreach (vecs[v]) begin
         do_start(0, 1'b0);
         send_bits(0, 8, vecs[v].a, vecs[v].b, vecs[v].gaps, vecs[v].exp);
         check_result(0, vecs[v].name, 9 + vecs[v].gaps);
         consume(0, vecs[v].name);
      end

      // Result held under backpressure with junk bits and an illegal start.
      do_start(0, 1'b0);
      send_bits(0, 8, 8'h5A, 8'h3C, 0, 3'b100);
      check_result(0, "hold", 9);
      held = {fgt[0], feq[0], flt[0]};
      for (int k = 0; k < 5; k++) begin
         bv[0] = 1'b1;
         ab[0] = 1'($urandom);
         bb[0] = 1'($urandom);
         step();
         check("hold_stable", int'({rv[0], fgt[0], feq[0], flt[0]}), int'({1'b1, held}));
      end
      bv[0] = 1'b0;
      p = perr_cnt[0];
      st[0] = 1'b1;
      step();
      st[0] = 1'b0;
      step();
      check("hold_start_err", perr_cnt[0] - p, 1);
      check("hold_start_kept", int'({rv[0], bsy[0], fgt[0], feq[0], flt[0]}), int'({2'b10, held}));
      consume(0, "hold");

      // Start coincident with res_ready chains straight into SHIFT.
      do_start(0, 1'b0);
      send_bits(0, 8, 8'h11, 8'h11, 0, 3'b010);
      check_result(0, "chain_a", 9);
      p = perr_cnt[0];
      do_start(0, 1'b1);
      check("chain_busy", int'({bsy[0], rv[0]}), 2);
      send_bits(0, 8, 8'h40, 8'h41, 0, 3'b001);
      check_result(0, "chain_b", 9);
      check("chain_noerr", perr_cnt[0] - p, 0);
      consume(0, "chain_b");

      // Restart after 4 bits: the first partial stream must be discarded.
      p = perr_cnt[0];
      do_start(0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         bv[0] = 1'b1;
         ab[0] = 1'b1;
         bb[0] = 1'b0;
         step();
      end
      st[0] = 1'b1;
      ab[0] = 1'b1;
      bb[0] = 1'b0;
      step();
      st[0] = 1'b0;
      bv[0] = 1'b0;
      t0[0] = cyc;
      send_bits(0, 8, 8'h01, 8'h02, 0, 3'b001);
      check_result(0, "restart", 9);
      check("restart_err", perr_cnt[0] - p, 1);
      consume(0, "restart");

      // Asynchronous reset in the middle of SHIFT.
      do_start(0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         bv[0] = 1'b1;
         ab[0] = 1'b0;
         bb[0] = 1'b1;
         step();
      end
      bv[0] = 1'b0;
      check("pre_rst_busy", int'(bsy[0]), 1);
      #2 rst_n = 1'b0;
      #1 check("async_rst", int'({bsy[0], rv[0], fgt[0], feq[0], flt[0], pe[0]}), 0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         bv[0] = 1'b1;
         ab[0] = 1'($urandom);
         bb[0] = 1'($urandom);
         step();
      end
      bv[0] = 1'b0;
      check("post_rst_idle", int'({bsy[0], rv[0]}), 0);

      // WIDTH=2 exhaustive, back-to-back.
      do_start(1, 1'b0);
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            send_bits(1, 2, 8'(a), 8'(b), 0, {a > b, a == b, a < b});
            check_result(1, $sformatf("w2_%0d_%0d", a, b), 3);
            if (a == 3 && b == 3) consume(1, "w2");
            else do_start(1, 1'b1);
         end
      end

      // WIDTH=1: a single beat goes straight to HOLD.
      for (int k = 0; k < 3; k++) begin
         logic [7:0] a1, b1;
         a1 = (k == 1) ? 8'd0 : 8'd1;
         b1 = (k == 0) ? 8'd0 : 8'd1;
         do_start(2, 1'b0);
         send_bits(2, 1, a1, b1, 0, {a1 > b1, a1 == b1, a1 < b1});
         check_result(2, $sformatf("w1_%0d", k), 2);
         consume(2, "w1");
      end

      check("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/compar_serial.md
Name: compar_serial

Overview:
Bit-serial magnitude comparator. Accepts two unsigned WIDTH-bit operands one bit per accepted beat, MSB first, and produces registered one-hot A_gt_B / A_eq_B / A_lt_B flags with a valid/ready result handshake. It sits at the consumer end of a serial operand link, where pins or area rule out the parallel compar_2b.

Parameters:
WIDTH, 8, operand length in bits; legal range ≥1.
CNT_W, $clog2(WIDTH) (minimum 1), bit counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new comparison (single-cycle pulse)
bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle
a_bit  input  1  current bit of operand A, MSB first
b_bit  input  1  current bit of operand B, MSB first
busy  output  1  high in SHIFT state
res_valid  output  1  result available
res_ready  input  1  downstream accepts the result
A_gt_B  output  1  A > B; qualified by res_valid
A_eq_B  output  1  A == B; qualified by res_valid
A_lt_B  output  1  A < B; qualified by res_valid
protocol_err  output  1  one-cycle pulse on an illegal start

Behaviour:
- One clock (clk); reset rst_n is asynchronous, active-low. While rst_n=0: state=IDLE, counter=0, and busy, res_valid, A_gt_B, A_eq_B, A_lt_B and protocol_err are all 0. Reset mid-operation discards the comparison in progress.
- All outputs are registered. Compare flags read 0 whenever res_valid=0. When res_valid=1, exactly one flag is 1.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - bit_valid is ignored.
  - start=1 -> SHIFT next cycle; cnt=0; decision registers cleared (decided=0, gt=0, lt=0).
  - The start cycle itself carries no bit.
- SHIFT (busy=1):
  - On each cycle with bit_valid=1: if decided=0 and a_bit≠b_bit, set decided=1, gt=a_bit, lt=b_bit. Then cnt++.
  - Once decided, later bits have no effect.
  - bit_valid=0 stalls; state and counter hold.
  - Accepting a bit with cnt==WIDTH-1 -> HOLD next cycle, res_valid=1. Flags: gt / lt as decided, eq = ~decided.
  - start=1 in SHIFT: comparison restarts (cnt=0, decision cleared), a bit on the same cycle is discarded, and protocol_err pulses for 1 cycle.
- HOLD (res_valid=1):
  - Flags are stable until the handshake completes.
  - res_ready=1 -> IDLE next cycle; res_valid and flags drop to 0.
  - res_ready=1 with start=1 on the same cycle: result is consumed and the FSM goes directly to SHIFT with cleared state. This is legal and gives no error.
  - start=1 with res_ready=0: start is ignored, protocol_err pulses, result is held.
  - bit_valid is ignored.
- Latency: start at cycle 0 and bits on cycles 1..WIDTH with no gaps -> res_valid rises at cycle WIDTH+1. Each stall cycle adds 1.
- Throughput: back-to-back comparisons cost WIDTH+1 cycles each when start coincides with res_ready.
- WIDTH=1: a single bit beat goes straight to HOLD.
- Counter arithmetic: compare cnt against WIDTH-1 only, with no reliance on wrap-around. The counter never exceeds WIDTH-1.

Decomposition:
- Shared package compar_pkg holds:
  - state enum (IDLE, SHIFT, HOLD)
  - a one-hot result typedef {gt, eq, lt} reused by compar_2b consumers
  - a localparam function for CNT_W
- One natural sub-module, compar_serial_cell: holds the decided/gt/lt registers and their update on bit beats, with a clear input.
- The FSM, counter and handshake stay in compar_serial.

Test Plan:
1. WIDTH=8, start, then A=0xA5, B=0xA5 on 8 consecutive beats -> res_valid at cycle 9 with A_eq_B=1, others 0.
2. A=0x80, B=0x7F -> A_gt_B=1 (decided on the MSB). Repeat with B's LSBs randomised -> same result.
3. A=0x3C, B=0x3D with 3 bit_valid=0 gap cycles inserted mid-stream -> A_lt_B=1, res_valid at cycle 12.
4. Hold res_ready=0 for 5 cycles in HOLD with bit_valid and random bits -> flags stable. Raise res_ready -> res_valid=0 next cycle. Repeat with start+res_ready together -> busy=1 next cycle, no protocol_err.
5. start again after 4 bits, then a full new operand pair A=0x01, B=0x02 -> one protocol_err pulse, result A_lt_B=1. Separately, assert rst_n=0 mid-SHIFT -> all outputs 0 asynchronously and state is IDLE after release.
6. WIDTH=2, exhaustive 16 A/B pairs back-to-back -> each flag matches A>B / A==B / A<B. WIDTH=1 with pairs (1,0), (0,1), (1,1) -> gt, lt, eq.
